data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- LANES, 6, vector lanes per memory word.
- LANE_W, 8, bits per lane.
- ADDR_W, 32, address width.
- MAX_OWN, 16, maximum consecutive cycles of locked ownership.

REQ-002 Ports SHALL be exactly these, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- cpu_req / com_req, in, 1, access request.
- cpu_we / com_we, in, 1, 1 = write, 0 = read.
- cpu_lock / com_lock, in, 1, request to keep ownership across cycles.
- cpu_addr / com_addr, in, ADDR_W, word address.
- cpu_wdata / com_wdata, in, LANES x LANE_W packed, write data.
- cpu_gnt / com_gnt, out, 1, access issued this cycle.
- cpu_rvalid / com_rvalid, out, 1, read data valid.
- cpu_rdata / com_rdata, out, LANES x LANE_W, read data.
- mem_we, out, 1, data memory write enable.
- mem_addr, out, ADDR_W, data memory address.
- mem_wdata, out, LANES x LANE_W, data memory write data.
- mem_rdata, in, LANES x LANE_W, data memory combinational read data.
- owner, out, 2, current state code: IDLE=0, OWN_CPU=1, OWN_COM=2.

Function
REQ-003 The arbiter SHALL grant at most one requester per cycle; cpu_gnt and com_gnt SHALL never both be 1.
REQ-004 Grants SHALL be combinational from the current state and requests; an access is issued in the cycle its gnt is 1.
REQ-005 In a grant cycle, mem_addr and mem_wdata SHALL carry the granted port's signals, and mem_we SHALL equal the granted port's we; with no grant, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold their last issued values.
REQ-006 A granted read SHALL register mem_rdata into that port's rdata at the clock edge; rvalid SHALL be 1 for exactly the following cycle. Latency is 1 cycle.
REQ-007 A granted write SHALL produce no rvalid, and rdata SHALL hold its previous value.
REQ-008 FSM states SHALL be IDLE, OWN_CPU and OWN_COM.
REQ-009 In IDLE, a single requester SHALL be granted. On contention the requester not recorded in the last-grant register wins.
REQ-010 Every grant SHALL update the last-grant register to the granted port.
REQ-011 In IDLE, a grant whose lock is 1 SHALL transition to OWN_x of the granted port and load the ownership counter with 1.
REQ-012 In OWN_x, only port x SHALL be granted, whenever x_req is 1. The counter SHALL increment every cycle, whether or not port x requests.
REQ-013 OWN_x SHALL return to IDLE at the edge where either condition holds:
- x_lock is 0, or
- the counter equals MAX_OWN-1.
On a forced release the other port SHALL win the next contention.
REQ-014 Lock held with req low SHALL keep ownership without granting and still consume counter cycles; the other port stays blocked until release.
REQ-015 When a requester's lock is 0 in its grant cycle, the FSM SHALL remain in IDLE.
REQ-016 No request SHALL ever be granted outside its req cycle. A dropped req SHALL be treated as withdrawn, with no buffering.

Reset
REQ-017 While reset is 0, regardless of clk:
- state = IDLE, counter = 0, last-grant = COM (so the CPU wins the first contention);
- both rvalid = 0, both rdata = 0;
- mem_addr = 0, mem_wdata = 0, mem_we = 0, both gnt = 0.
REQ-018 A read granted in the cycle reset asserts SHALL produce no rvalid after reset release. Reset mid-ownership SHALL drop ownership.

Structure
REQ-019 The shared package SHALL hold:
- the LANES, LANE_W and ADDR_W defaults;
- the vector word typedef (LANES x LANE_W packed);
- the owner state enum {IDLE, OWN_CPU, OWN_COM};
- the port-index enum {CPU, COM}.
REQ-020 A single sub-module rr_pick SHALL compute the two-way round-robin winner from both reqs and the last-grant register. All other logic SHALL stay in data_mem_arbiter.

Verification
REQ-021 After reset release, cpu_req = com_req = 1, both reads, no lock. Required: cycle 0 cpu_gnt = 1, cycle 1 com_gnt = 1, alternating thereafter; rvalid on each port one cycle after its grant.
REQ-022 com write addr = 0x10, wdata = 0x0605_0403_0201, then cpu read addr = 0x10. Required: mem_we = 1 only in the com grant cycle; cpu_rdata = 0x060504030201 with cpu_rvalid = 1.
REQ-023 cpu_lock = 1 and cpu_req = 1 held, com_req = 1. Required: cpu_gnt for exactly 16 consecutive cycles, then com_gnt = 1 in cycle 17; owner goes 1 then 0.
REQ-024 com_lock = 1 with com_req dropped for 3 cycles, then com_lock = 0, while cpu_req = 1. Required: no cpu_gnt until the cycle after lock falls; counter has advanced 4.
REQ-025 Reset asserted asynchronously mid-cycle during a granted cpu read inside OWN_CPU. Required: owner = 0, cpu_rvalid = 0, mem_we = 0 immediately; first post-release contention goes to the CPU.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the data memory arbiter and its round-robin picker.
package data_mem_arbiter_pkg;

  localparam int DEF_LANES  = 6;
  localparam int DEF_LANE_W = 8;
  localparam int DEF_ADDR_W = 32;

  // One vector memory word: LANES lanes of LANE_W bits, lane 0 in the low bits.
  typedef logic [DEF_LANES*DEF_LANE_W-1:0] vword_t;

  // Owner state; the encoding is visible on the owner port.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_COM = 2'd2
  } owner_e;

  // Requester index, used for the last-grant register.
  typedef enum logic {
    CPU = 1'b0,
    COM = 1'b1
  } port_e;

endpackage

// File: rtl/data_mem_arbiter_rr_pick.sv
// Two-way round-robin winner: a lone requester wins, on contention the port
// that was not granted last wins.
module rr_pick
  import data_mem_arbiter_pkg::*;
(
  input  logic  cpu_req,
  input  logic  com_req,
  input  port_e last,
  output logic  pick_cpu,
  output logic  pick_com
);

  // Pick at most one winner from the two requests and the last-grant record.
  always_comb begin
    pick_cpu = 1'b0;
    pick_com = 1'b0;
    if (cpu_req && com_req) begin
      if (last == COM) pick_cpu = 1'b1;
      else             pick_com = 1'b1;
    end else if (cpu_req) begin
      pick_cpu = 1'b1;
    end else if (com_req) begin
      pick_com = 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates a single-ported vector data memory between the CPU and a
// coprocessor. Grants are combinational; a locked grant keeps ownership for a
// bounded number of cycles. Read data comes back one cycle after the grant.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int LANE_W  = DEF_LANE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MAX_OWN = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic                    cpu_lock,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [LANES*LANE_W-1:0] cpu_wdata,
  input  logic                    com_req,
  input  logic                    com_we,
  input  logic                    com_lock,
  input  logic [ADDR_W-1:0]       com_addr,
  input  logic [LANES*LANE_W-1:0] com_wdata,
  output logic                    cpu_gnt,
  output logic                    cpu_rvalid,
  output logic [LANES*LANE_W-1:0] cpu_rdata,
  output logic                    com_gnt,
  output logic                    com_rvalid,
  output logic [LANES*LANE_W-1:0] com_rdata,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANES*LANE_W-1:0] mem_wdata,
  input  logic [LANES*LANE_W-1:0] mem_rdata,
  output logic [1:0]              owner
);

  localparam int DW = LANES * LANE_W;
  localparam int CW = $clog2(MAX_OWN + 1);

  owner_e          state_q, state_d;
  port_e           last_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DW-1:0]   wdata_q;
  logic            pick_cpu, pick_com;

  rr_pick u_rr_pick (
    .cpu_req  (cpu_req),
    .com_req  (com_req),
    .last     (last_q),
    .pick_cpu (pick_cpu),
    .pick_com (pick_com)
  );

  assign owner = state_q;

  // Grant decode; held low while reset is asserted so nothing reaches memory.
  always_comb begin
    cpu_gnt = 1'b0;
    com_gnt = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          cpu_gnt = pick_cpu;
          com_gnt = pick_com;
        end
        OWN_CPU: cpu_gnt = cpu_req;
        OWN_COM: com_gnt = com_req;
        default: ;
      endcase
    end
  end

  // Memory command mux; address and data hold the last issued access when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (com_gnt) begin
      mem_we    = com_we;
      mem_addr  = com_addr;
      mem_wdata = com_wdata;
    end
  end

  // Ownership next-state: lock on a locked grant, release on unlock or when the budget runs out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_gnt && cpu_lock) begin
          state_d = OWN_CPU;
          cnt_d   = CW'(1);
        end else if (com_gnt && com_lock) begin
          state_d = OWN_COM;
          cnt_d   = CW'(1);
        end
      end
      OWN_CPU: begin
        cnt_d = cnt_q + CW'(1);
        if (!cpu_lock || cnt_q == CW'(MAX_OWN - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      OWN_COM: begin
        cnt_d = cnt_q + CW'(1);
        if (!com_lock || cnt_q == CW'(MAX_OWN - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbitration state: owner, ownership counter, last grant and held memory command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= COM;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cpu_gnt)      last_q <= CPU;
      else if (com_gnt) last_q <= COM;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  // Read return path: capture memory data for granted reads, pulse rvalid one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rvalid <= 1'b0;
      com_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      com_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt && !cpu_we;
      com_rvalid <= com_gnt && !com_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
      if (com_gnt && !com_we) com_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: directed steps check grants, owner and the
// memory command each cycle; read returns go through a scoreboard queue that
// a separate monitor drains whenever an rvalid shows up.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  localparam int DW = DEF_LANES * DEF_LANE_W;
  localparam int AW = DEF_ADDR_W;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_lock;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          com_req, com_we, com_lock;
  logic [AW-1:0] com_addr;
  logic [DW-1:0] com_wdata;
  logic          cpu_gnt, cpu_rvalid, com_gnt, com_rvalid;
  logic [DW-1:0] cpu_rdata, com_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    owner;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  exp_t          cpu_q[$];
  exp_t          com_q[$];
  int            checks = 0;
  int            passed = 0;
  int            cyc = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;

  data_mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_lock   (cpu_lock),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .com_req    (com_req),
    .com_we     (com_we),
    .com_lock   (com_lock),
    .com_addr   (com_addr),
    .com_wdata  (com_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .com_gnt    (com_gnt),
    .com_rvalid (com_rvalid),
    .com_rdata  (com_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .owner      (owner)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected read returns.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural data memory: combinational read, write on the clock edge.
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[7:0]];

  // Every word starts as its low address byte replicated in all six lanes.
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = {6{8'(i)}};
      ref_mem[i] = {6{8'(i)}};
    end
  end

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(
    input logic cr, input logic cw, input logic cl, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
    input logic mr, input logic mw, input logic ml, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    @(negedge clk);
    cpu_req = cr; cpu_we = cw; cpu_lock = cl; cpu_addr = ca; cpu_wdata = cd;
    com_req = mr; com_we = mw; com_lock = ml; com_addr = ma; com_wdata = md;
  endtask

  task automatic checkOutput(input string name, input logic egc, input logic egm,
                             input logic [1:0] eown, input bit track);
    logic emwe;
    #1;
    emwe = (egc & cpu_we) | (egm & com_we);
    if (egc) begin
      exp_addr  = cpu_addr;
      exp_wdata = cpu_wdata;
    end else if (egm) begin
      exp_addr  = com_addr;
      exp_wdata = com_wdata;
    end
    compare({name, " cpu_gnt"},   64'(cpu_gnt),   64'(egc));
    compare({name, " com_gnt"},   64'(com_gnt),   64'(egm));
    compare({name, " owner"},     64'(owner),     64'(eown));
    compare({name, " mem_we"},    64'(mem_we),    64'(emwe));
    compare({name, " mem_addr"},  64'(mem_addr),  64'(exp_addr));
    compare({name, " mem_wdata"}, 64'(mem_wdata), 64'(exp_wdata));
    if (track) begin
      if (egc && !cpu_we) cpu_q.push_back('{cyc + 1, ref_mem[cpu_addr[7:0]]});
      if (egm && !com_we) com_q.push_back('{cyc + 1, ref_mem[com_addr[7:0]]});
      if (egc && cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
      if (egm && com_we) ref_mem[com_addr[7:0]] = com_wdata;
    end
  endtask

  // Monitor: pop and compare an expected read whenever a port raises rvalid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cpu_rvalid) begin
        if (cpu_q.size() == 0) compare("cpu unexpected rvalid", 64'(cpu_rvalid), 64'(0));
        else begin
          e = cpu_q.pop_front();
          compare("cpu rvalid cycle", 64'(cyc), 64'(e.cyc));
          compare("cpu rdata", 64'(cpu_rdata), 64'(e.data));
        end
      end else if (cpu_q.size() > 0 && cpu_q[0].cyc <= cyc) begin
        void'(cpu_q.pop_front());
        compare("cpu missing rvalid", 64'(cpu_rvalid), 64'(1));
      end
      if (com_rvalid) begin
        if (com_q.size() == 0) compare("com unexpected rvalid", 64'(com_rvalid), 64'(0));
        else begin
          e = com_q.pop_front();
          compare("com rvalid cycle", 64'(cyc), 64'(e.cyc));
          compare("com rdata", 64'(com_rdata), 64'(e.data));
        end
      end else if (com_q.size() > 0 && com_q[0].cyc <= cyc) begin
        void'(com_q.pop_front());
        compare("com missing rvalid", 64'(com_rvalid), 64'(1));
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = 32'h3; cpu_wdata = '0;
    com_req = 1'b1; com_we = 1'b1; com_lock = 1'b0; com_addr = 32'h4; com_wdata = 48'hABCD;

    // Reset state, with both requests raised to show reset gates the grants.
    @(negedge clk);
    @(negedge clk);
    #1;
    compare("rst owner",      64'(owner),      64'(0));
    compare("rst cpu_gnt",    64'(cpu_gnt),    64'(0));
    compare("rst com_gnt",    64'(com_gnt),    64'(0));
    compare("rst mem_we",     64'(mem_we),     64'(0));
    compare("rst mem_addr",   64'(mem_addr),   64'(0));
    compare("rst mem_wdata",  64'(mem_wdata),  64'(0));
    compare("rst cpu_rvalid", 64'(cpu_rvalid), 64'(0));
    compare("rst com_rvalid", 64'(com_rvalid), 64'(0));
    compare("rst cpu_rdata",  64'(cpu_rdata),  64'(0));
    compare("rst com_rdata",  64'(com_rdata),  64'(0));
    applyStimulus(0, 0, 0, 32'h0, '0, 0, 0, 0, 32'h0, '0);
    reset = 1'b1;
    checkOutput("idle", 0, 0, 2'd0, 1);

    // Both ports reading without lock: CPU first, then strict alternation.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 32'(i + 1), '0, 1, 0, 0, 32'(8'h20 + i), '0);
      checkOutput($sformatf("alt%0d", i), (i % 2) == 0, (i % 2) == 1, 2'd0, 1);
    end

    // COM writes a word, CPU reads it back.
    applyStimulus(0, 0, 0, 32'h0, '0, 1, 1, 0, 32'h10, 48'h0605_0403_0201);
    checkOutput("com write", 0, 1, 2'd0, 1);
    applyStimulus(1, 0, 0, 32'h10, '0, 0, 0, 0, 32'h0, '0);
    checkOutput("cpu readback", 1, 0, 2'd0, 1);
    applyStimulus(0, 0, 0, 32'h0, '0, 0, 0, 0, 32'h0, '0);
    checkOutput("readback idle", 0, 0, 2'd0, 1);
    compare("readback rvalid", 64'(cpu_rvalid), 64'(1));
    compare("readback rdata",  64'(cpu_rdata),  64'h0605_0403_0201);

    // Lone COM read leaves last-grant on COM so the CPU wins the next contention.
    applyStimulus(0, 0, 0, 32'h0, '0, 1, 0, 0, 32'h21, '0);
    checkOutput("com single", 0, 1, 2'd0, 1);

    // CPU locks with COM waiting: 16 CPU grants, then COM on the forced release.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 0, 1, 32'(8'h30 + i), '0, 1, 0, 0, 32'h40, '0);
      checkOutput($sformatf("lock%0d", i), i < 16, i == 16, (i == 0 || i == 16) ? 2'd0 : 2'd1, 1);
    end

    // COM locks, then idles under lock; CPU is blocked until the cycle after unlock.
    applyStimulus(0, 0, 0, 32'h0, '0, 1, 0, 1, 32'h50, '0);
    checkOutput("com lock", 0, 1, 2'd0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 32'h51, '0, 0, 0, 1, 32'h0, '0);
      checkOutput($sformatf("com hold%0d", i), 0, 0, 2'd2, 1);
    end
    applyStimulus(1, 0, 0, 32'h51, '0, 0, 0, 0, 32'h0, '0);
    checkOutput("com unlock", 0, 0, 2'd2, 1);
    applyStimulus(1, 0, 0, 32'h51, '0, 0, 0, 0, 32'h0, '0);
    checkOutput("cpu after unlock", 1, 0, 2'd0, 1);

    // Reset lands mid-cycle during a granted CPU read inside CPU ownership.
    applyStimulus(1, 0, 1, 32'h60, '0, 0, 0, 0, 32'h0, '0);
    checkOutput("cpu lock2", 1, 0, 2'd0, 1);
    applyStimulus(1, 0, 1, 32'h61, '0, 1, 0, 0, 32'h62, '0);
    checkOutput("own read", 1, 0, 2'd1, 0);
    #1 reset = 1'b0;
    #1;
    exp_addr  = '0;
    exp_wdata = '0;
    compare("async owner",      64'(owner),      64'(0));
    compare("async cpu_rvalid", 64'(cpu_rvalid), 64'(0));
    compare("async mem_we",     64'(mem_we),     64'(0));
    compare("async cpu_gnt",    64'(cpu_gnt),    64'(0));
    compare("async mem_addr",   64'(mem_addr),   64'(0));
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1, 0, 0, 32'h7, '0, 1, 0, 0, 32'h8, '0);
    reset = 1'b1;
    checkOutput("post rst", 1, 0, 2'd0, 1);
    applyStimulus(1, 0, 0, 32'h7, '0, 1, 0, 0, 32'h8, '0);
    checkOutput("post rst alt", 0, 1, 2'd0, 1);
    applyStimulus(0, 0, 0, 32'h0, '0, 0, 0, 0, 32'h0, '0);
    checkOutput("tail0", 0, 0, 2'd0, 1);
    applyStimulus(0, 0, 0, 32'h0, '0, 0, 0, 0, 32'h0, '0);
    checkOutput("tail1", 0, 0, 2'd0, 1);
    @(negedge clk);
    #1;
    compare("cpu queue drained", 64'(cpu_q.size()), 64'(0));
    compare("com queue drained", 64'(com_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
